// File: rtl/uart_pkg.sv
// uart_pkg: state encodings and bit-timing helper shared by the UART RX and TX
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_state_t;
  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial input and received-byte outputs of the UART receiver
interface uart_rx_if;
  logic       rx_line;
  logic [7:0] data;
  logic       rx_done;
  logic       rx_busy;
  logic       frame_err;
  modport master (output rx_line, input data, rx_done, rx_busy, frame_err);
  modport slave (input rx_line, output data, rx_done, rx_busy, frame_err);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= RESET_VAL;
      r_q    <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end
  assign o_q = r_q;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with glitch rejection, framing-error and break handling
module uart_rx
  import uart_pkg::*;
#(
  parameter int clk_freq  = 50000000,
  parameter int baud_rate = 9600
) (
  input logic clk,
  input logic reset,
  uart_rx_if.slave bus
);
  localparam logic [15:0] CPB  = 16'(clks_per_bit(clk_freq, baud_rate));
  localparam logic [15:0] HALF = (CPB - 16'd1) / 16'd2;
  logic        w_rx;
  logic        w_fall;
  uart_state_t r_state, w_state_n;
  logic [15:0] r_cnt, w_cnt_n;
  logic [2:0]  r_idx, w_idx_n;
  logic [7:0]  r_shift, w_shift_n;
  logic [7:0]  r_data, w_data_n;
  logic        r_prev, r_done, r_ferr, w_done_n, w_ferr_n;
  sync_2ff #(.RESET_VAL(1'b1)) u_sync (.clk(clk), .reset(reset), .i_d(bus.rx_line), .o_q(w_rx));
  assign w_fall = r_prev & ~w_rx;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_prev  <= 1'b1;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_idx   <= w_idx_n;
      r_shift <= w_shift_n;
      r_data  <= w_data_n;
      r_prev  <= w_rx;
      r_done  <= w_done_n;
      r_ferr  <= w_ferr_n;
    end
  end
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt + 16'd1;
    w_idx_n   = r_idx;
    w_shift_n = r_shift;
    w_data_n  = r_data;
    w_done_n  = 1'b0;
    w_ferr_n  = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_n   = '0;
        w_state_n = w_fall ? START : IDLE;
      end
      START: if (r_cnt == HALF) begin
        w_cnt_n   = '0;
        w_idx_n   = '0;
        w_state_n = w_rx ? IDLE : DATA;
      end
      DATA: if (r_cnt == CPB - 16'd1) begin
        w_cnt_n   = '0;
        w_shift_n = {w_rx, r_shift[7:1]};
        w_idx_n   = r_idx + 3'd1;
        w_state_n = (r_idx == 3'd7) ? STOP : DATA;
      end
      STOP: if (r_cnt == CPB - 16'd1) begin
        w_cnt_n   = '0;
        w_state_n = w_rx ? IDLE : BREAK;
        w_done_n  = w_rx;
        w_ferr_n  = ~w_rx;
        w_data_n  = w_rx ? r_shift : r_data;
      end
      BREAK: begin
        w_cnt_n   = '0;
        w_state_n = w_rx ? IDLE : BREAK;
      end
      default: w_state_n = IDLE;
    endcase
  end
  assign bus.data      = r_data;
  assign bus.rx_done   = r_done;
  assign bus.frame_err = r_ferr;
  assign bus.rx_busy   = (r_state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed checks of uart_rx at 10 clocks per bit, plus a 256-byte serial loopback
module tb_uart_rx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  int both_cnt = 0;
  logic busy_seen = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  uart_rx_if u_if ();
  uart_rx #(.clk_freq(1000000), .baud_rate(100000)) dut (.clk(clk), .reset(reset), .bus(u_if.slave));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (!reset) begin
      if (u_if.rx_done) begin
        done_cnt++;
        got_q.push_back(u_if.data);
      end
      if (u_if.frame_err) ferr_cnt++;
      if (u_if.rx_done && u_if.frame_err) both_cnt++;
      if (u_if.rx_busy) busy_seen = 1'b1;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic bit_out(input logic v, input int n);
    u_if.rx_line = v;
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] b, input logic stop_bit);
    bit_out(1'b0, 10);
    for (int i = 0; i < 8; i++) bit_out(b[i], 10);
    bit_out(stop_bit, 10);
  endtask
  task automatic clr();
    done_cnt = 0;
    ferr_cnt = 0;
    busy_seen = 1'b0;
    got_q.delete();
  endtask
  initial begin
    logic [7:0] b;
    logic [7:0] v;
    u_if.rx_line = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(u_if.data), 32'h0);
    chk("rst_done", 32'(u_if.rx_done), 32'h0);
    chk("rst_busy", 32'(u_if.rx_busy), 32'h0);
    chk("rst_ferr", 32'(u_if.frame_err), 32'h0);
    reset = 1'b0;
    bit_out(1'b1, 20);
    clr();
    send(8'hA5, 1'b1);
    bit_out(1'b1, 5);
    chk("a5_data", 32'(u_if.data), 32'hA5);
    chk("a5_done", 32'(done_cnt), 32'd1);
    chk("a5_ferr", 32'(ferr_cnt), 32'd0);
    chk("a5_busy", 32'(u_if.rx_busy), 32'h0);
    bit_out(1'b1, 15);
    clr();
    b = 8'h3C;
    bit_out(1'b0, 10);
    for (int i = 0; i < 8; i++) bit_out(b[i], 10);
    bit_out(1'b0, 40);
    chk("brk_ferr", 32'(ferr_cnt), 32'd1);
    chk("brk_done", 32'(done_cnt), 32'd0);
    chk("brk_data", 32'(u_if.data), 32'hA5);
    chk("brk_busy", 32'(u_if.rx_busy), 32'h1);
    bit_out(1'b1, 5);
    chk("brk_idle", 32'(u_if.rx_busy), 32'h0);
    bit_out(1'b1, 15);
    clr();
    bit_out(1'b0, 3);
    bit_out(1'b1, 20);
    chk("gl_seen", 32'(busy_seen), 32'h1);
    chk("gl_busy", 32'(u_if.rx_busy), 32'h0);
    chk("gl_done", 32'(done_cnt), 32'd0);
    chk("gl_ferr", 32'(ferr_cnt), 32'd0);
    clr();
    b = 8'h12;
    bit_out(1'b0, 10);
    for (int i = 0; i < 4; i++) bit_out(b[i], 10);
    bit_out(b[4], 5);
    reset = 1'b1;
    bit_out(1'b1, 2);
    chk("mr_data", 32'(u_if.data), 32'h0);
    chk("mr_done", 32'(u_if.rx_done), 32'h0);
    chk("mr_busy", 32'(u_if.rx_busy), 32'h0);
    chk("mr_ferr", 32'(u_if.frame_err), 32'h0);
    bit_out(1'b1, 10);
    reset = 1'b0;
    bit_out(1'b1, 10);
    chk("mr_nopulse", 32'(done_cnt + ferr_cnt), 32'd0);
    send(8'h5A, 1'b1);
    bit_out(1'b1, 5);
    chk("mr_5a", 32'(u_if.data), 32'h5A);
    chk("mr_5a_done", 32'(done_cnt), 32'd1);
    chk("mr_5a_ferr", 32'(ferr_cnt), 32'd0);
    bit_out(1'b1, 15);
    clr();
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    bit_out(1'b1, 5);
    chk("b2b_done", 32'(done_cnt), 32'd2);
    chk("b2b_ferr", 32'(ferr_cnt), 32'd0);
    chk("b2b_first", 32'(got_q.size() > 0 ? got_q[0] : 8'hEE), 32'h00);
    chk("b2b_second", 32'(got_q.size() > 1 ? got_q[1] : 8'hEE), 32'hFF);
    bit_out(1'b1, 15);
    clr();
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom_range(0, 255));
      exp_q.push_back(v);
      send(v, 1'b1);
    end
    bit_out(1'b1, 10);
    chk("lb_count", 32'(done_cnt), 32'd256);
    chk("lb_ferr", 32'(ferr_cnt), 32'd0);
    for (int i = 0; i < 256; i++)
      chk($sformatf("lb_byte%0d", i), 32'(i < got_q.size() ? got_q[i] : 8'hEE), 32'(exp_q[i]));
    chk("excl", 32'(both_cnt), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
